fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch stage for the pipelined processor. It replaces the bare PC register, PC incrementer and IF/ID register with one unit that contains a program counter, a prefetch queue of depth QUEUE_DEPTH, decode-side backpressure (stall) and branch redirect with queue flush. It sits between the combinational instruction memory and the decoder. It presents one {PC, instruction} pair per cycle under a valid/stall handshake.

Parameters:
PC_WIDTH, 10, width of PC and instruction-memory address; PC wraps modulo 2^PC_WIDTH.
INSTR_WIDTH, 16, instruction word width.
QUEUE_DEPTH, 4, prefetch entries; power of two, >= 2.
RESET_PC, 0, fetch address after reset.

Ports:
Clock  in  1  system clock; all state updates on rising edge.
Reset  in  1  asynchronous, active-low reset (0 = reset).
oIMemAddress  out  PC_WIDTH  fetch address to the instruction memory (equals fetch PC).
oIMemRequest  out  1  1 = the word on iIMemInstruction is captured this cycle.
iIMemInstruction  in  INSTR_WIDTH  memory data; combinational read of oIMemAddress, same cycle.
iBranchTaken  in  1  redirect request from the branch-resolution stage.
iBranchTarget  in  PC_WIDTH  redirect address; sampled when iBranchTaken=1.
iStall  in  1  decoder cannot accept; head entry is held.
oValid  out  1  head entry is valid.
oInstruction  out  INSTR_WIDTH  head instruction; 0 when oValid=0.
oInstrPC  out  PC_WIDTH  PC of head instruction; 0 when oValid=0.
oQueueCount  out  clog2(QUEUE_DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (Reset=0, takes effect immediately, no clock needed): fetch PC=RESET_PC, queue empty, count=0. oValid=0, oInstruction=0, oInstrPC=0, oQueueCount=0. oIMemAddress=RESET_PC. oIMemRequest=0 while Reset=0.
- Pop: pop = oValid & ~iStall & ~iBranchTaken.
- Push:
  - push = ~iBranchTaken & (count<QUEUE_DEPTH | pop).
  - oIMemRequest = push.
  - On push, {fetch PC, iIMemInstruction} is written at the tail and fetch PC <= fetch PC+1, wrapping from 2^PC_WIDTH-1 to 0.
- Push and pop in the same cycle: count unchanged. A push with a full queue is legal only together with a pop.
- Latency: an instruction fetched in cycle N is at the head, with oValid=1, in cycle N+1 at the earliest. First oValid=1 is the first rising edge after reset release plus one cycle.
- Outputs are taken from registered queue storage. There is no combinational path from iIMemInstruction to oInstruction.
- Redirect (iBranchTaken=1): highest priority, overriding stall, push and pop. At the edge: queue flushed (count=0), fetch PC <= iBranchTarget. oIMemRequest=0 in the redirect cycle. Next cycle the target is fetched (oValid=0). The cycle after, oValid=1 with oInstrPC=target. Redirect-to-valid latency is 2 cycles.
- Back-to-back redirects: each one flushes the queue; only the last target is fetched.
- Stall: head entry and oInstruction/oInstrPC hold stable. Fetch continues until the queue is full. After that, oIMemRequest=0 and fetch PC holds.
- Stall release: entries drain one per cycle with no bubbles while the memory supplies data.
- Queue pointers: head and tail wrap modulo QUEUE_DEPTH. Full and empty are decided by count, never by pointer equality alone.
- Reset asserted mid-operation: all state is discarded immediately. Fetch restarts at RESET_PC after release.

Test Plan:
Common setup: defaults, with a memory model returning instr = 0x1000 + address.
1. Release Reset, iStall=0, no branches: cycle 1 oValid=1, oInstrPC=0x000, oInstruction=0x1000. Then PCs 0x001, 0x002, ... one per cycle; oQueueCount stays 1.
2. iStall=1 for 6 cycles from reset release: oQueueCount climbs to 4, then oIMemRequest=0 and oInstrPC holds 0x000. Release stall: oInstrPC 0x000, 0x001, ..., 0x005 on consecutive cycles, no gaps.
3. Free-running, pulse iBranchTaken=1 with iBranchTarget=0x155 for 1 cycle: next cycle oValid=0 and oQueueCount=0. The following cycle oInstrPC=0x155, oInstruction=0x1155, then 0x156.
4. Queue full under iStall=1, then iBranchTaken=1 with target 0x020 (stall still 1): queue flushed, oInstrPC=0x020 two cycles later, held while stalled.
5. RESET_PC=0x3FE, no stall: oInstrPC sequence 0x3FE, 0x3FF, 0x000, 0x001.
6. Drive Reset=0 between clock edges while 3 entries are queued: oValid, oQueueCount, oInstruction and oInstrPC go to 0 before the next edge. After release, the first valid oInstrPC=RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: program counter plus prefetch queue feeding the decoder,
// with stall backpressure and branch redirect that flushes the queue.
module fetch_queue_unit #(
    parameter int                  PC_WIDTH    = 10,
    parameter int                  INSTR_WIDTH = 16,
    parameter int                  QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                               Clock,
    input  logic                               Reset,
    output logic [PC_WIDTH-1:0]                oIMemAddress,
    output logic                               oIMemRequest,
    input  logic [INSTR_WIDTH-1:0]             iIMemInstruction,
    input  logic                               iBranchTaken,
    input  logic [PC_WIDTH-1:0]                iBranchTarget,
    input  logic                               iStall,
    output logic                               oValid,
    output logic [INSTR_WIDTH-1:0]             oInstruction,
    output logic [PC_WIDTH-1:0]                oInstrPC,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   oQueueCount
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [CW-1:0]          count;
    logic [AW-1:0]          head, tail;
    logic [PC_WIDTH-1:0]    pc_mem [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [QUEUE_DEPTH];
    logic                   pop, push;

    // A full queue still accepts a new word when the head leaves in the same cycle.
    always_comb begin
        pop  = oValid & ~iStall & ~iBranchTaken;
        push = ~iBranchTaken & ((count != FULL) | pop);
    end

    assign oValid       = count != '0;
    assign oInstruction = oValid ? instr_mem[head] : '0;
    assign oInstrPC     = oValid ? pc_mem[head] : '0;
    assign oQueueCount  = count;
    assign oIMemAddress = fetch_pc;
    assign oIMemRequest = push & Reset;

    always_ff @(posedge Clock) begin
        if (push) begin
            pc_mem[tail]    <= fetch_pc;
            instr_mem[tail] <= iIMemInstruction;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (iBranchTaken) begin
            fetch_pc <= iBranchTarget;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 1'b1;
                tail     <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
